// File: rtl/frame_mem_arbiter_if.sv
// Bus bundle between the frame-memory arbiter, its two requesters and the frame RAM.
// The arbiter takes the slave modport; requesters and RAM together form the master side.
interface frame_mem_arbiter_if;
  logic        vga_req;
  logic [18:0] vga_addr;
  logic [7:0]  vga_data;
  logic        vga_valid;

  logic        flt_req;
  logic        flt_we;
  logic [18:0] flt_addr;
  logic [7:0]  flt_wdata;
  logic        flt_gnt;
  logic [7:0]  flt_rdata;
  logic        flt_rvalid;

  logic [18:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic        starve;

  modport slave (
    input  vga_req, vga_addr, flt_req, flt_we, flt_addr, flt_wdata, mem_rdata,
    output vga_data, vga_valid, flt_gnt, flt_rdata, flt_rvalid,
           mem_addr, mem_we, mem_wdata, starve
  );

  modport master (
    output vga_req, vga_addr, flt_req, flt_we, flt_addr, flt_wdata, mem_rdata,
    input  vga_data, vga_valid, flt_gnt, flt_rdata, flt_rvalid,
           mem_addr, mem_we, mem_wdata, starve
  );
endinterface

// File: rtl/frame_mem_arbiter.sv
// Single-port frame RAM arbiter: display reads have strict priority, the filter engine
// takes idle cycles through req/gnt; read data is routed back by a tag pipeline.
module frame_mem_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int MEM_DEPTH  = 307200,
  parameter int STARVE_LIM = 16
) (
  input logic                 clk,
  input logic                 reset,
  frame_mem_arbiter_if.slave  bus
);

  typedef struct packed {
    logic valid;
    logic owner_flt;
    logic oob;
  } tag_t;

  logic       vga_oob;
  logic       flt_oob;
  tag_t       tag_d;
  tag_t       tag_q [1:RD_LAT];
  tag_t       ret;
  logic [7:0] ret_data;
  logic [7:0] starve_cnt;

  assign vga_oob = {13'd0, bus.vga_addr} >= MEM_DEPTH;
  assign flt_oob = {13'd0, bus.flt_addr} >= MEM_DEPTH;

  assign bus.flt_gnt = bus.flt_req & ~bus.vga_req & ~reset;

  // Stage 0 of the tag pipeline: the read being arbitrated this cycle.
  always_comb begin
    // NOTE: default first so every path assigns tag_d and no latch is inferred.
    tag_d = '0;
    if (bus.vga_req)
      tag_d = '{valid: 1'b1, owner_flt: 1'b0, oob: vga_oob};
    else if (bus.flt_gnt && !bus.flt_we)
      tag_d = '{valid: 1'b1, owner_flt: 1'b1, oob: flt_oob};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      bus.mem_we <= 1'b0;
      if (bus.vga_req) begin
        if (!vga_oob) bus.mem_addr <= bus.vga_addr;
      end else if (bus.flt_gnt) begin
        bus.mem_wdata <= bus.flt_wdata;
        // Out-of-range accesses leave the RAM address alone and never write.
        if (!flt_oob) begin
          bus.mem_addr <= bus.flt_addr;
          bus.mem_we   <= bus.flt_we;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the tag flops are reset so no stale response escapes after reset; the RAM itself never is.
      for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[1] <= tag_d;
      for (int i = 2; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign ret      = tag_q[RD_LAT];
  assign ret_data = ret.oob ? 8'h00 : bus.mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.vga_data   <= '0;
      bus.vga_valid  <= 1'b0;
      bus.flt_rdata  <= '0;
      bus.flt_rvalid <= 1'b0;
    end else begin
      bus.vga_valid  <= 1'b0;
      bus.flt_rvalid <= 1'b0;
      if (ret.valid) begin
        if (ret.owner_flt) begin
          bus.flt_rdata  <= ret_data;
          bus.flt_rvalid <= 1'b1;
        end else begin
          bus.vga_data  <= ret_data;
          bus.vga_valid <= 1'b1;
        end
      end
    end
  end

  // Consecutive-denial counter; saturates so starve stays up until the filter is served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      starve_cnt <= '0;
    else if (!bus.flt_req || bus.flt_gnt)
      starve_cnt <= '0;
    else if (starve_cnt != 8'(STARVE_LIM))
      starve_cnt <= starve_cnt + 8'd1;
  end

  assign bus.starve = (starve_cnt == 8'(STARVE_LIM));

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Self-checking bench for frame_mem_arbiter: a queue-based response model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_frame_mem_arbiter;

  localparam int RD_LAT     = 1;
  localparam int MEM_DEPTH  = 307200;
  localparam int STARVE_LIM = 16;
  localparam int PIPE_IDX   = (RD_LAT >= 2) ? RD_LAT - 2 : 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   started = 1'b0;
  int   checks = 0;
  int   errors = 0;

  frame_mem_arbiter_if bus ();

  frame_mem_arbiter #(
    .RD_LAT(RD_LAT), .MEM_DEPTH(MEM_DEPTH), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Frame RAM: write on the clock edge, read data due RD_LAT edges after mem_addr is issued.
  logic [7:0] tb_ram [0:524287];
  logic [7:0] rd_pipe [0:3];

  always @(posedge clk) begin
    if (bus.mem_we) tb_ram[bus.mem_addr] <= bus.mem_wdata;
    rd_pipe[0] <= tb_ram[bus.mem_addr];
    for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign bus.mem_rdata = (RD_LAT == 1) ? tb_ram[bus.mem_addr] : rd_pipe[PIPE_IDX];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a queue of outstanding responses, each with its due cycle and data.
  typedef struct {
    int         due;
    bit         to_flt;
    logic [7:0] data;
  } resp_t;

  resp_t      pend[$];
  logic [7:0] model_ram [int];
  int         cyc;
  int         starve_n;
  logic [18:0] exp_mem_addr;
  logic        exp_mem_we;
  logic [7:0]  exp_mem_wdata;
  logic [7:0]  exp_vga_data, exp_flt_rdata;
  logic        exp_vga_valid, exp_flt_rvalid, exp_starve;

  function automatic logic [7:0] model_read(input logic [18:0] a);
    if (int'(a) >= MEM_DEPTH) return 8'h00;
    return model_ram.exists(int'(a)) ? model_ram[int'(a)] : 8'h00;
  endfunction

  always @(posedge clk or posedge reset) begin
    resp_t r;
    if (reset) begin
      cyc = 0;
      starve_n = 0;
      pend.delete();
      exp_mem_addr   <= '0;
      exp_mem_we     <= 1'b0;
      exp_mem_wdata  <= '0;
      exp_vga_data   <= '0;
      exp_vga_valid  <= 1'b0;
      exp_flt_rdata  <= '0;
      exp_flt_rvalid <= 1'b0;
      exp_starve     <= 1'b0;
    end else begin
      cyc++;
      exp_vga_valid  <= 1'b0;
      exp_flt_rvalid <= 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        if (r.to_flt) begin
          exp_flt_rdata  <= r.data;
          exp_flt_rvalid <= 1'b1;
        end else begin
          exp_vga_data  <= r.data;
          exp_vga_valid <= 1'b1;
        end
      end
      exp_mem_we <= 1'b0;
      if (bus.vga_req) begin
        pend.push_back('{cyc + RD_LAT, 1'b0, model_read(bus.vga_addr)});
        if (int'(bus.vga_addr) < MEM_DEPTH) exp_mem_addr <= bus.vga_addr;
      end else if (bus.flt_req) begin
        exp_mem_wdata <= bus.flt_wdata;
        if (bus.flt_we) begin
          if (int'(bus.flt_addr) < MEM_DEPTH) begin
            exp_mem_we   <= 1'b1;
            exp_mem_addr <= bus.flt_addr;
            model_ram[int'(bus.flt_addr)] = bus.flt_wdata;
          end
        end else begin
          pend.push_back('{cyc + RD_LAT, 1'b1, model_read(bus.flt_addr)});
          if (int'(bus.flt_addr) < MEM_DEPTH) exp_mem_addr <= bus.flt_addr;
        end
      end
      if (bus.flt_req && bus.vga_req)
        starve_n = (starve_n < STARVE_LIM) ? starve_n + 1 : STARVE_LIM;
      else
        starve_n = 0;
      exp_starve <= (starve_n == STARVE_LIM);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("flt_gnt",    bus.flt_gnt,    bus.flt_req & ~bus.vga_req & ~reset);
      check("mem_addr",   bus.mem_addr,   exp_mem_addr);
      check("mem_we",     bus.mem_we,     exp_mem_we);
      if (exp_mem_we) check("mem_wdata", bus.mem_wdata, exp_mem_wdata);
      check("vga_valid",  bus.vga_valid,  exp_vga_valid);
      check("vga_data",   bus.vga_data,   exp_vga_data);
      check("flt_rvalid", bus.flt_rvalid, exp_flt_rvalid);
      check("flt_rdata",  bus.flt_rdata,  exp_flt_rdata);
      check("starve",     bus.starve,     exp_starve);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 524288; i++) tb_ram[i] = 8'h00;
    tb_ram[5] = 8'hA5; tb_ram[7] = 8'h11; tb_ram[8] = 8'h22;
    model_ram[5] = 8'hA5; model_ram[7] = 8'h11; model_ram[8] = 8'h22;
    bus.vga_req = 0; bus.vga_addr = '0;
    bus.flt_req = 0; bus.flt_we = 0; bus.flt_addr = '0; bus.flt_wdata = '0;

    @(posedge clk);
    started = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    smp;
    check("rst_mem_addr",  bus.mem_addr,  19'd0);
    check("rst_vga_data",  bus.vga_data,  8'h00);
    check("rst_flt_rdata", bus.flt_rdata, 8'h00);
    check("rst_starve",    bus.starve,    1'b0);

    // Display read of addr 5.
    tick;
    bus.vga_req = 1; bus.vga_addr = 19'd5;
    tick;
    bus.vga_req = 0;
    smp;
    check("t2_mem_addr", bus.mem_addr, 19'd5);
    check("t2_no_valid", bus.vga_valid, 1'b0);
    tick;
    smp;
    check("t2_vga_valid", bus.vga_valid, 1'b1);
    check("t2_vga_data",  bus.vga_data,  8'hA5);
    tick;
    smp;
    check("t2_pulse_end", bus.vga_valid, 1'b0);
    check("t2_data_held", bus.vga_data,  8'hA5);

    // Collision: display wins, filter write goes the next cycle.
    tick;
    bus.vga_req = 1; bus.vga_addr = 19'd8;
    bus.flt_req = 1; bus.flt_we = 1; bus.flt_addr = 19'd9; bus.flt_wdata = 8'h3C;
    smp;
    check("t3_gnt_denied", bus.flt_gnt, 1'b0);
    tick;
    bus.vga_req = 0;
    smp;
    check("t3_gnt", bus.flt_gnt, 1'b1);
    tick;
    bus.flt_req = 0; bus.flt_we = 0;
    smp;
    check("t3_mem_we",    bus.mem_we,    1'b1);
    check("t3_mem_addr",  bus.mem_addr,  19'd9);
    check("t3_mem_wdata", bus.mem_wdata, 8'h3C);

    // Back-to-back filter read then display read.
    tick;
    bus.flt_req = 1; bus.flt_we = 0; bus.flt_addr = 19'd7;
    tick;
    bus.flt_req = 0;
    bus.vga_req = 1; bus.vga_addr = 19'd8;
    tick;
    bus.vga_req = 0;
    smp;
    check("t4_flt_rvalid", bus.flt_rvalid, 1'b1);
    check("t4_flt_rdata",  bus.flt_rdata,  8'h11);
    check("t4_vga_early",  bus.vga_valid,  1'b0);
    tick;
    smp;
    check("t4_vga_valid",  bus.vga_valid,  1'b1);
    check("t4_vga_data",   bus.vga_data,   8'h22);
    check("t4_flt_end",    bus.flt_rvalid, 1'b0);

    // Starvation: filter held off by continuous display reads.
    tick;
    bus.vga_req = 1; bus.vga_addr = 19'd5;
    bus.flt_req = 1; bus.flt_we = 0; bus.flt_addr = 19'd7;
    for (int i = 0; i < STARVE_LIM; i++) begin
      smp;
      check("t5_starve_low", bus.starve, 1'b0);
      tick;
    end
    smp;
    check("t5_starve_high", bus.starve, 1'b1);
    tick;
    bus.vga_req = 0;
    smp;
    check("t5_gnt",       bus.flt_gnt, 1'b1);
    check("t5_saturated", bus.starve,  1'b1);
    tick;
    bus.flt_req = 0;
    smp;
    check("t5_starve_clr", bus.starve, 1'b0);
    tick;
    smp;
    check("t5_rdata", bus.flt_rdata, 8'h11);

    // Out-of-range write then read.
    tick;
    bus.flt_req = 1; bus.flt_we = 1; bus.flt_addr = 19'd307200; bus.flt_wdata = 8'h55;
    smp;
    check("t6_wr_gnt", bus.flt_gnt, 1'b1);
    tick;
    bus.flt_we = 0;
    smp;
    check("t6_no_we",     bus.mem_we,   1'b0);
    check("t6_addr_hold", bus.mem_addr, 19'd7);
    tick;
    bus.flt_req = 0;
    smp;
    check("t6_no_we2",     bus.mem_we,     1'b0);
    check("t6_addr_hold2", bus.mem_addr,   19'd7);
    check("t6_not_yet",    bus.flt_rvalid, 1'b0);
    tick;
    smp;
    check("t6_rvalid", bus.flt_rvalid, 1'b1);
    check("t6_rdata",  bus.flt_rdata,  8'h00);

    // Reset asserted mid-cycle with reads in flight.
    tick;
    bus.vga_req = 1; bus.vga_addr = 19'd8;
    tick;
    bus.vga_req = 0;
    bus.flt_req = 1; bus.flt_we = 0; bus.flt_addr = 19'd7;
    #2 reset = 1'b1;
    #1;
    check("t1_mem_addr", bus.mem_addr,   19'd0);
    check("t1_vga_data", bus.vga_data,   8'h00);
    check("t1_flt_gnt",  bus.flt_gnt,    1'b0);
    check("t1_mem_we",   bus.mem_we,     1'b0);
    check("t1_rvalid",   bus.flt_rvalid, 1'b0);
    bus.flt_req = 0;
    tick;
    tick;
    reset = 1'b0;
    for (int i = 0; i < RD_LAT + 2; i++) begin
      smp;
      check("t1_no_vga_valid", bus.vga_valid,  1'b0);
      check("t1_no_flt_valid", bus.flt_rvalid, 1'b0);
      tick;
    end

    repeat (2) tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
